axi_isolate_drain: RTL and testbench



---
 rtl/axi_isolate_drain.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_isolate_drain.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_isolate_drain.sv
// axi_isolate_drain
//   Single-clock AXI gate placed in front of the source port of an AXI clock-domain
//   crossing. Traffic passes through combinationally. Only the valid and ready
//   signals are gated. Outstanding reads and writes are counted so the gate can cap
//   them. On request the gate stops accepting new transactions and drains the ones
//   in flight. It then reports that the port is quiet.
//
// Ports
//   clk_i       clock
//   rst_i       synchronous, active-high reset
//   isolate_i   level request. 1 = block new transactions and drain the port
//   isolated_o  1 = no transaction outstanding and no new ones accepted
//   slv_req_i   request from the upstream master
//   slv_resp_o  response to the upstream master
//   mst_req_o   request toward the CDC source port
//   mst_resp_i  response from the CDC source port

// Default AXI channel and bundle types. An integrator can pass any structs with the
// same field names through the type parameters.
package axi_isolate_drain_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } axi_resp_t;

endpackage

module axi_isolate_drain #(
  parameter type         axi_req_t  = axi_isolate_drain_pkg::axi_req_t,
  parameter type         axi_resp_t = axi_isolate_drain_pkg::axi_resp_t,
  parameter int unsigned MaxTxns    = 8
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      isolate_i,
  output logic      isolated_o,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i
);

  localparam int unsigned         CntWidth = $clog2(MaxTxns + 1);
  localparam logic [CntWidth-1:0] CntMax   = CntWidth'(MaxTxns);

  typedef enum logic [1:0] {
    Normal,
    Drain,
    Isolated
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] wrCnt_q, wrCnt_d;
  logic [CntWidth-1:0] rdCnt_q, rdCnt_d;
  logic                awHold_q, awHold_d;
  logic                arHold_q, arHold_d;
  logic                isolated_q;

  logic awGate, arGate, passWbr;
  logic awHs, arHs, bHs, rLastHs;

  // Gate the address channels while a counter is full or the port is not in normal
  // operation. The hold flag overrides the gate. An address valid that is already
  // shown downstream must stay up until it handshakes, because AXI forbids
  // withdrawing it. W, B and R are cut only in the isolated state. Reset cuts every
  // valid and ready, so nothing can handshake while tracking is being cleared.
  always_comb begin
    awGate  = ~awHold_q & ((wrCnt_q == CntMax) | (state_q != Normal));
    arGate  = ~arHold_q & ((rdCnt_q == CntMax) | (state_q != Normal));
    passWbr = ~rst_i & (state_q != Isolated);

    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid & ~awGate & ~rst_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ~arGate & ~rst_i;
    mst_req_o.w_valid  = slv_req_i.w_valid & passWbr;
    mst_req_o.b_ready  = slv_req_i.b_ready & passWbr;
    mst_req_o.r_ready  = slv_req_i.r_ready & passWbr;

    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~awGate & ~rst_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~arGate & ~rst_i;
    slv_resp_o.w_ready  = mst_resp_i.w_ready & passWbr;
    slv_resp_o.b_valid  = mst_resp_i.b_valid & passWbr;
    slv_resp_o.r_valid  = mst_resp_i.r_valid & passWbr;
  end

  assign awHs    = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign arHs    = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign bHs     = mst_resp_i.b_valid & mst_req_o.b_ready;
  assign rLastHs = mst_resp_i.r_valid & mst_req_o.r_ready & mst_resp_i.r.last;

  // Outstanding counters and valid-hold flags. An opening handshake and a closing
  // handshake in the same cycle cancel out. The address gate keeps each counter at
  // or below MaxTxns, so the counters never wrap.
  always_comb begin
    wrCnt_d = wrCnt_q;
    if (awHs && !bHs) begin
      wrCnt_d = wrCnt_q + 1'b1;
    end else if (!awHs && bHs) begin
      wrCnt_d = wrCnt_q - 1'b1;
    end

    rdCnt_d = rdCnt_q;
    if (arHs && !rLastHs) begin
      rdCnt_d = rdCnt_q + 1'b1;
    end else if (!arHs && rLastHs) begin
      rdCnt_d = rdCnt_q - 1'b1;
    end

    awHold_d = awHold_q;
    if (awHs) begin
      awHold_d = 1'b0;
    end else if (mst_req_o.aw_valid) begin
      awHold_d = 1'b1;
    end

    arHold_d = arHold_q;
    if (arHs) begin
      arHold_d = 1'b0;
    end else if (mst_req_o.ar_valid) begin
      arHold_d = 1'b1;
    end
  end

  // Isolation state machine. Dropping the request always wins and returns to normal
  // operation. Isolation is entered only when nothing is counted and no address
  // valid is held. In that state the address gates are closed and a closing
  // handshake would be illegal, so no transaction can complete during the cycle
  // that moves into isolation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Normal: begin
        if (isolate_i) begin
          state_d = Drain;
        end
      end
      Drain: begin
        if (!isolate_i) begin
          state_d = Normal;
        end else if ((wrCnt_q == '0) && (rdCnt_q == '0) && !awHold_q && !arHold_q) begin
          state_d = Isolated;
        end
      end
      Isolated: begin
        if (!isolate_i) begin
          state_d = Normal;
        end
      end
      default: state_d = Normal;
    endcase
  end

  // State and tracking registers. The isolated flag is registered from the next
  // state, so it goes high on the same edge as the isolated state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= Normal;
      wrCnt_q    <= '0;
      rdCnt_q    <= '0;
      awHold_q   <= 1'b0;
      arHold_q   <= 1'b0;
      isolated_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrCnt_q    <= wrCnt_d;
      rdCnt_q    <= rdCnt_d;
      awHold_q   <= awHold_d;
      arHold_q   <= arHold_d;
      isolated_q <= (state_d == Isolated);
    end
  end

  assign isolated_o = isolated_q;

  // A response that arrives with nothing outstanding means the downstream side lost
  // track. This usually happens when one side was reset without the other.
  bWithoutAw: assert property (@(posedge clk_i) disable iff (rst_i) bHs |-> (wrCnt_q != '0));
  rWithoutAr: assert property (@(posedge clk_i) disable iff (rst_i) rLastHs |-> (rdCnt_q != '0));
  wrCntBound: assert property (@(posedge clk_i) disable iff (rst_i) wrCnt_q <= CntMax);
  rdCntBound: assert property (@(posedge clk_i) disable iff (rst_i) rdCnt_q <= CntMax);

endmodule

// File: tb/tb_axi_isolate_drain.sv
// tb_axi_isolate_drain
//   Self-checking bench for axi_isolate_drain. dutA uses MaxTxns=8 for the
//   pass-through and isolation scenarios. dutB uses MaxTxns=2 for the limit scenario.

module tb_axi_isolate_drain;
  import axi_isolate_drain_pkg::*;

  logic      clk;
  logic      rst;
  logic      isoA, isoB;
  logic      isolatedA, isolatedB;
  axi_req_t  slvReqA, mstReqA, slvReqB, mstReqB;
  axi_resp_t slvRespA, mstRespA, slvRespB, mstRespB;

  int checkCount = 0;
  int passCount  = 0;

  ax_chan_t axQ[$];
  w_chan_t  wQ[$];
  b_chan_t  bQ[$];
  r_chan_t  rQ[$];

  axi_isolate_drain #(.MaxTxns(8)) dutA (
    .clk_i(clk), .rst_i(rst), .isolate_i(isoA), .isolated_o(isolatedA),
    .slv_req_i(slvReqA), .slv_resp_o(slvRespA), .mst_req_o(mstReqA), .mst_resp_i(mstRespA)
  );

  axi_isolate_drain #(.MaxTxns(2)) dutB (
    .clk_i(clk), .rst_i(rst), .isolate_i(isoB), .isolated_o(isolatedB),
    .slv_req_i(slvReqB), .slv_resp_o(slvRespB), .mst_req_o(mstReqB), .mst_resp_i(mstRespB)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends, even if a scenario stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleAll();
    slvReqA  = '0;
    mstRespA = '0;
    slvReqB  = '0;
    mstRespB = '0;
    isoA     = 1'b0;
    isoB     = 1'b0;
  endtask

  // Reset gates every valid and ready. After reset, the counters and the
  // isolated flag read zero.
  task automatic test_reset();
    idleAll();
    rst = 1'b1;
    slvReqA.aw_valid = 1'b1; slvReqA.w_valid = 1'b1; slvReqA.ar_valid = 1'b1;
    slvReqA.b_ready = 1'b1;  slvReqA.r_ready = 1'b1;
    mstRespA.aw_ready = 1'b1; mstRespA.w_ready = 1'b1; mstRespA.ar_ready = 1'b1;
    mstRespA.b_valid = 1'b1;  mstRespA.r_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if ({mstReqA.aw_valid, mstReqA.w_valid, mstReqA.ar_valid} !== 3'b000)
      $display("[TB] FAIL reset_mst_valids: got %b, expected 000",
               {mstReqA.aw_valid, mstReqA.w_valid, mstReqA.ar_valid});
    else passCount++;
    checkCount++;
    if ({slvRespA.aw_ready, slvRespA.w_ready, slvRespA.ar_ready, slvRespA.b_valid, slvRespA.r_valid} !== 5'b0)
      $display("[TB] FAIL reset_slv_handshake: got %b, expected 00000",
               {slvRespA.aw_ready, slvRespA.w_ready, slvRespA.ar_ready, slvRespA.b_valid, slvRespA.r_valid});
    else passCount++;
    rst = 1'b0;
    idleAll();
    #1;
    checkCount++;
    if ({isolatedA, isolatedB, dutA.wrCnt_q, dutA.rdCnt_q} !== 10'b0)
      $display("[TB] FAIL reset_state: got iso=%b/%b wr=%0d rd=%0d, expected all 0",
               isolatedA, isolatedB, dutA.wrCnt_q, dutA.rdCnt_q);
    else passCount++;
  endtask

  // Four 4-beat writes and then four 2-beat reads, all forwarded with no added
  // latency. The scoreboard compares every forwarded payload.
  task automatic test_pass_through();
    ax_chan_t ax, expAx;
    w_chan_t  w, expW;
    b_chan_t  b, expB;
    r_chan_t  r, expR;
    idleAll();
    mstRespA.aw_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ax.id = 4'(i); ax.addr = $urandom; ax.len = 8'd3;
      slvReqA.aw = ax; slvReqA.aw_valid = 1'b1;
      axQ.push_back(ax);
      #1;
      checkCount++;
      if (!mstReqA.aw_valid) $display("[TB] FAIL pt_aw%0d: mst aw_valid=0, expected 1", i);
      else begin
        expAx = axQ.pop_front();
        if ({slvRespA.aw_ready, mstReqA.aw} !== {1'b1, expAx})
          $display("[TB] FAIL pt_aw%0d: got %h, expected %h", i, {slvRespA.aw_ready, mstReqA.aw}, {1'b1, expAx});
        else passCount++;
      end
      nextCycle();
    end
    slvReqA.aw_valid = 1'b0;
    checkCount++;
    if (dutA.wrCnt_q !== 4'd4) $display("[TB] FAIL pt_wr_peak: got %0d, expected 4", dutA.wrCnt_q);
    else passCount++;

    mstRespA.w_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      w.data = $urandom; w.strb = 4'($urandom); w.last = ((j % 4) == 3);
      slvReqA.w = w; slvReqA.w_valid = 1'b1;
      wQ.push_back(w);
      #1;
      checkCount++;
      if (!mstReqA.w_valid) $display("[TB] FAIL pt_w%0d: mst w_valid=0, expected 1", j);
      else begin
        expW = wQ.pop_front();
        if ({slvRespA.w_ready, mstReqA.w} !== {1'b1, expW})
          $display("[TB] FAIL pt_w%0d: got %h, expected %h", j, {slvRespA.w_ready, mstReqA.w}, {1'b1, expW});
        else passCount++;
      end
      nextCycle();
    end
    slvReqA.w_valid = 1'b0;

    slvReqA.b_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b.id = 4'(i); b.resp = 2'($urandom);
      mstRespA.b = b; mstRespA.b_valid = 1'b1;
      bQ.push_back(b);
      #1;
      checkCount++;
      if (!slvRespA.b_valid) $display("[TB] FAIL pt_b%0d: slv b_valid=0, expected 1", i);
      else begin
        expB = bQ.pop_front();
        if ({mstReqA.b_ready, slvRespA.b} !== {1'b1, expB})
          $display("[TB] FAIL pt_b%0d: got %h, expected %h", i, {mstReqA.b_ready, slvRespA.b}, {1'b1, expB});
        else passCount++;
      end
      nextCycle();
    end
    mstRespA.b_valid = 1'b0;
    checkCount++;
    if (dutA.wrCnt_q !== 4'd0) $display("[TB] FAIL pt_wr_end: got %0d, expected 0", dutA.wrCnt_q);
    else passCount++;

    mstRespA.ar_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ax.id = 4'(i + 8); ax.addr = $urandom; ax.len = 8'd1;
      slvReqA.ar = ax; slvReqA.ar_valid = 1'b1;
      axQ.push_back(ax);
      #1;
      checkCount++;
      if (!mstReqA.ar_valid) $display("[TB] FAIL pt_ar%0d: mst ar_valid=0, expected 1", i);
      else begin
        expAx = axQ.pop_front();
        if ({slvRespA.ar_ready, mstReqA.ar} !== {1'b1, expAx})
          $display("[TB] FAIL pt_ar%0d: got %h, expected %h", i, {slvRespA.ar_ready, mstReqA.ar}, {1'b1, expAx});
        else passCount++;
      end
      nextCycle();
    end
    slvReqA.ar_valid = 1'b0;
    checkCount++;
    if (dutA.rdCnt_q !== 4'd4) $display("[TB] FAIL pt_rd_peak: got %0d, expected 4", dutA.rdCnt_q);
    else passCount++;

    slvReqA.r_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      r.id = 4'((j / 2) + 8); r.data = $urandom; r.resp = 2'b00; r.last = ((j % 2) == 1);
      mstRespA.r = r; mstRespA.r_valid = 1'b1;
      rQ.push_back(r);
      #1;
      checkCount++;
      if (!slvRespA.r_valid) $display("[TB] FAIL pt_r%0d: slv r_valid=0, expected 1", j);
      else begin
        expR = rQ.pop_front();
        if ({mstReqA.r_ready, slvRespA.r} !== {1'b1, expR})
          $display("[TB] FAIL pt_r%0d: got %h, expected %h", j, {mstReqA.r_ready, slvRespA.r}, {1'b1, expR});
        else passCount++;
      end
      nextCycle();
    end
    idleAll();
    checkCount++;
    if (dutA.rdCnt_q !== 4'd0) $display("[TB] FAIL pt_rd_end: got %0d, expected 0", dutA.rdCnt_q);
    else passCount++;
  endtask

  // With MaxTxns=2, a third AW waits until the cycle after the first B.
  task automatic test_limit();
    idleAll();
    slvReqB.aw.addr = 32'h1000; slvReqB.aw_valid = 1'b1;
    mstRespB.aw_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checkCount++;
      if (slvRespB.aw_ready !== 1'b1) $display("[TB] FAIL lim_accept%0d: aw_ready=%b, expected 1", i, slvRespB.aw_ready);
      else passCount++;
      nextCycle();
    end
    checkCount++;
    if ({slvRespB.aw_ready, mstReqB.aw_valid, dutB.wrCnt_q} !== 4'b0010)
      $display("[TB] FAIL lim_full: got ready=%b valid=%b cnt=%0d, expected 0 0 2",
               slvRespB.aw_ready, mstReqB.aw_valid, dutB.wrCnt_q);
    else passCount++;
    nextCycle();
    mstRespB.b_valid = 1'b1; slvReqB.b_ready = 1'b1;
    #1;
    checkCount++;
    if (slvRespB.aw_ready !== 1'b0) $display("[TB] FAIL lim_b_cycle: aw_ready=%b, expected 0", slvRespB.aw_ready);
    else passCount++;
    nextCycle();
    mstRespB.b_valid = 1'b0;
    #1;
    checkCount++;
    if (slvRespB.aw_ready !== 1'b1) $display("[TB] FAIL lim_third: aw_ready=%b, expected 1", slvRespB.aw_ready);
    else passCount++;
    nextCycle();
    slvReqB.aw_valid = 1'b0;
    mstRespB.b_valid = 1'b1;
    repeat (2) nextCycle();
    idleAll();
    checkCount++;
    if (dutB.wrCnt_q !== 2'd0) $display("[TB] FAIL lim_end: got %0d, expected 0", dutB.wrCnt_q);
    else passCount++;
  endtask

  // Two writes and one read are outstanding when isolation is requested. A new AR
  // is blocked, while B and R still flow. The port reports isolated one cycle after
  // the last response.
  task automatic test_drain();
    b_chan_t b, expB;
    idleAll();
    slvReqA.aw_valid = 1'b1; mstRespA.aw_ready = 1'b1;
    repeat (2) nextCycle();
    slvReqA.aw_valid = 1'b0;
    slvReqA.ar_valid = 1'b1; mstRespA.ar_ready = 1'b1;
    nextCycle();
    slvReqA.ar_valid = 1'b0;
    isoA = 1'b1;
    nextCycle();
    slvReqA.ar_valid = 1'b1;
    #1;
    checkCount++;
    if ({mstReqA.ar_valid, slvRespA.ar_ready, isolatedA} !== 3'b000)
      $display("[TB] FAIL drain_ar_block: got %b, expected 000", {mstReqA.ar_valid, slvRespA.ar_ready, isolatedA});
    else passCount++;
    nextCycle();
    slvReqA.ar_valid = 1'b0;
    slvReqA.b_ready = 1'b1; slvReqA.r_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      b.id = 4'(i + 3); b.resp = 2'b01;
      mstRespA.b = b; mstRespA.b_valid = 1'b1;
      bQ.push_back(b);
      #1;
      checkCount++;
      if (!slvRespA.b_valid) $display("[TB] FAIL drain_b%0d: slv b_valid=0, expected 1", i);
      else begin
        expB = bQ.pop_front();
        if (slvRespA.b !== expB) $display("[TB] FAIL drain_b%0d: got %h, expected %h", i, slvRespA.b, expB);
        else passCount++;
      end
      nextCycle();
    end
    mstRespA.b_valid = 1'b0;
    mstRespA.r.last = 1'b1; mstRespA.r_valid = 1'b1;
    #1;
    checkCount++;
    if ({slvRespA.r_valid, mstReqA.r_ready} !== 2'b11)
      $display("[TB] FAIL drain_r: got %b, expected 11", {slvRespA.r_valid, mstReqA.r_ready});
    else passCount++;
    nextCycle();
    mstRespA.r_valid = 1'b0;
    checkCount++;
    if (isolatedA !== 1'b0) $display("[TB] FAIL drain_early: isolated=%b, expected 0", isolatedA);
    else passCount++;
    nextCycle();
    checkCount++;
    if ({isolatedA, dutA.wrCnt_q, dutA.rdCnt_q} !== 9'b1_0000_0000)
      $display("[TB] FAIL drain_done: got iso=%b wr=%0d rd=%0d, expected 1 0 0", isolatedA, dutA.wrCnt_q, dutA.rdCnt_q);
    else passCount++;
    slvReqA.w_valid = 1'b1; mstRespA.w_ready = 1'b1; mstRespA.b_valid = 1'b1;
    #1;
    checkCount++;
    if ({mstReqA.w_valid, slvRespA.w_ready, slvRespA.b_valid, mstReqA.b_ready} !== 4'b0000)
      $display("[TB] FAIL iso_wbr_block: got %b, expected 0000",
               {mstReqA.w_valid, slvRespA.w_ready, slvRespA.b_valid, mstReqA.b_ready});
    else passCount++;
    mstRespA.b_valid = 1'b0;
    isoA = 1'b0;
    nextCycle();
    checkCount++;
    if ({isolatedA, mstReqA.w_valid, slvRespA.w_ready} !== 3'b011)
      $display("[TB] FAIL iso_release: got %b, expected 011", {isolatedA, mstReqA.w_valid, slvRespA.w_ready});
    else passCount++;
    idleAll();
    nextCycle();
  endtask

  // An AW valid that is stalled downstream stays up through the drain. Its
  // handshake is counted before the port isolates.
  task automatic test_valid_stability();
    idleAll();
    slvReqA.aw_valid = 1'b1;
    nextCycle();
    isoA = 1'b1;
    #1;
    checkCount++;
    if (mstReqA.aw_valid !== 1'b1) $display("[TB] FAIL vs_rise: aw_valid=%b, expected 1", mstReqA.aw_valid);
    else passCount++;
    nextCycle();
    checkCount++;
    if (mstReqA.aw_valid !== 1'b1) $display("[TB] FAIL vs_drain: aw_valid=%b, expected 1", mstReqA.aw_valid);
    else passCount++;
    nextCycle();
    checkCount++;
    if ({isolatedA, mstReqA.aw_valid} !== 2'b01)
      $display("[TB] FAIL vs_held: got %b, expected 01", {isolatedA, mstReqA.aw_valid});
    else passCount++;
    mstRespA.aw_ready = 1'b1;
    nextCycle();
    slvReqA.aw_valid = 1'b0; mstRespA.aw_ready = 1'b0;
    checkCount++;
    if ({isolatedA, dutA.wrCnt_q} !== 5'b0_0001)
      $display("[TB] FAIL vs_counted: got iso=%b wr=%0d, expected 0 1", isolatedA, dutA.wrCnt_q);
    else passCount++;
    mstRespA.b_valid = 1'b1; slvReqA.b_ready = 1'b1;
    nextCycle();
    mstRespA.b_valid = 1'b0;
    nextCycle();
    checkCount++;
    if (isolatedA !== 1'b1) $display("[TB] FAIL vs_isolated: isolated=%b, expected 1", isolatedA);
    else passCount++;
    idleAll();
    nextCycle();
  endtask

  // An AW handshake and a B handshake in the same cycle leave the count unchanged.
  task automatic test_simultaneous();
    idleAll();
    slvReqA.aw_valid = 1'b1; mstRespA.aw_ready = 1'b1;
    nextCycle();
    mstRespA.b_valid = 1'b1; slvReqA.b_ready = 1'b1;
    nextCycle();
    slvReqA.aw_valid = 1'b0;
    checkCount++;
    if (dutA.wrCnt_q !== 4'd1) $display("[TB] FAIL sim_hs: got %0d, expected 1", dutA.wrCnt_q);
    else passCount++;
    nextCycle();
    idleAll();
    checkCount++;
    if (dutA.wrCnt_q !== 4'd0) $display("[TB] FAIL sim_end: got %0d, expected 0", dutA.wrCnt_q);
    else passCount++;
  endtask

  // On an idle port, isolated goes high two cycles after the request. Dropping the
  // request during the drain returns to normal without ever reporting isolated.
  task automatic test_isolate_timing();
    idleAll();
    isoA = 1'b1;
    nextCycle();
    checkCount++;
    if (isolatedA !== 1'b0) $display("[TB] FAIL lat_drain: isolated=%b, expected 0", isolatedA);
    else passCount++;
    nextCycle();
    checkCount++;
    if (isolatedA !== 1'b1) $display("[TB] FAIL lat_iso: isolated=%b, expected 1", isolatedA);
    else passCount++;
    isoA = 1'b0;
    nextCycle();
    slvReqA.w_valid = 1'b1; mstRespA.w_ready = 1'b1;
    #1;
    checkCount++;
    if ({isolatedA, mstReqA.w_valid} !== 2'b01)
      $display("[TB] FAIL lat_resume: got %b, expected 01", {isolatedA, mstReqA.w_valid});
    else passCount++;
    idleAll();
    isoA = 1'b1;
    nextCycle();
    isoA = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkCount++;
      if (isolatedA !== 1'b0) $display("[TB] FAIL abort%0d: isolated=%b, expected 0", i, isolatedA);
      else passCount++;
    end
  endtask

  // A one-cycle reset during a W burst gates everything in that cycle. It also
  // clears the tracking and any drain in progress.
  task automatic test_reset_mid_burst();
    idleAll();
    slvReqA.aw_valid = 1'b1; mstRespA.aw_ready = 1'b1;
    nextCycle();
    slvReqA.aw_valid = 1'b0;
    isoA = 1'b1;
    slvReqA.w_valid = 1'b1; mstRespA.w_ready = 1'b1;
    nextCycle();
    rst = 1'b1; isoA = 1'b0;
    slvReqA.aw_valid = 1'b1; slvReqA.ar_valid = 1'b1;
    mstRespA.ar_ready = 1'b1; mstRespA.b_valid = 1'b1; mstRespA.r_valid = 1'b1;
    #1;
    checkCount++;
    if ({mstReqA.aw_valid, mstReqA.w_valid, mstReqA.ar_valid,
         slvRespA.aw_ready, slvRespA.w_ready, slvRespA.ar_ready, slvRespA.b_valid, slvRespA.r_valid} !== 8'b0)
      $display("[TB] FAIL rmb_gated: got %b, expected 00000000",
               {mstReqA.aw_valid, mstReqA.w_valid, mstReqA.ar_valid,
                slvRespA.aw_ready, slvRespA.w_ready, slvRespA.ar_ready, slvRespA.b_valid, slvRespA.r_valid});
    else passCount++;
    nextCycle();
    rst = 1'b0;
    idleAll();
    #1;
    checkCount++;
    if ({isolatedA, dutA.wrCnt_q, dutA.rdCnt_q} !== 9'b0)
      $display("[TB] FAIL rmb_cleared: got iso=%b wr=%0d rd=%0d, expected 0 0 0", isolatedA, dutA.wrCnt_q, dutA.rdCnt_q);
    else passCount++;
    slvReqA.aw_valid = 1'b1; mstRespA.aw_ready = 1'b1;
    #1;
    checkCount++;
    if ({mstReqA.aw_valid, slvRespA.aw_ready} !== 2'b11)
      $display("[TB] FAIL rmb_normal: got %b, expected 11", {mstReqA.aw_valid, slvRespA.aw_ready});
    else passCount++;
    idleAll();
    nextCycle();
  endtask

  initial begin
    rst = 1'b1;
    idleAll();
    test_reset();
    nextCycle();
    test_pass_through();
    test_limit();
    test_drain();
    test_valid_stability();
    test_simultaneous();
    test_isolate_timing();
    test_reset_mid_burst();
    repeat (2) nextCycle();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
